axum_ctx_sched: RTL
===================

Name: axum_ctx_sched

Overview:
Context scheduler for the multi-context register file. It owns the register-context select and sequences every context switch: it drains the core pipeline through a halt handshake, picks the next ready context round-robin, then updates the select. It sits between the core's control logic and the register-file context select input. The context select is also the value the bus-mapped register window compares against.

Parameters:
NrCtx, 4, number of register contexts; power of two, 2..8.
CtxW, $clog2(NrCtx), width of context IDs (localparam-derived; not overridable).
QuantumCycles, 1024, preemption quantum in cycles; only used with AXUM_CTX_PREEMPT_EN; range 2..65535.

Ports:
- clk_i  in  1  clock; single clock domain
- rst_ni  in  1  asynchronous active-low reset
- ctx_wake_i  in  NrCtx  per-context wake pulse; sets that context's ready bit
- ctx_en_i  in  NrCtx  per-context enable mask; a disabled context is never selected
- ctx_yield_i  in  1  running context yields and is requeued (level sampled in RUN only)
- ctx_sleep_i  in  1  running context yields and is not requeued; sleep wins over yield if both are set
- halt_req_o  out  1  request the core to stop fetch and drain the pipeline
- halt_ack_i  in  1  core reports the pipeline is drained (level)
- ctx_sel_o  out  CtxW  active register context
- switch_done_o  out  1  one-cycle pulse when the new context is live
- busy_o  out  1  high in any state other than RUN
- ready_o  out  NrCtx  current ready-bit vector (debug and bus status)

Behaviour:
- Reset (asynchronous, any state):
  - state = RUN, ctx_sel_o = 0, ready_q = 0, halt_req_o = 0, switch_done_o = 0, busy_o = 0.
  - A reset mid-switch abandons the switch, and context 0 runs.
- Registered state: ready_q[NrCtx], next_q[CtxW], requeue_q, state.
- Wake handling, every cycle: ready_q |= ctx_wake_i.
  - Exception: in RUN, the wake bit of ctx_sel_o is dropped because that context is already running.
  - In DRAIN or SWITCH, a wake for the outgoing context is recorded, so a sleep followed by a wake is not lost.
- Candidate set: cand = ready_q & ctx_en_i with the ctx_sel_o bit masked.
  - Winner is the first set bit searching from ctx_sel_o+1 upward, wrapping modulo NrCtx.
- FSM:
  - RUN: on (yield | sleep) with cand != 0:
    - latch next_q = winner and requeue_q = yield & ~sleep;
    - halt_req_o <= 1; go to DRAIN.
  - RUN: on (yield | sleep) with cand == 0: the request is ignored and the state stays RUN, with no handshake.
  - DRAIN: hold halt_req_o = 1 and wait for halt_ack_i = 1 (no timeout); then go to SWITCH.
  - SWITCH (exactly 1 cycle):
    - ctx_sel_o <= next_q; clear ready_q[next_q];
    - if requeue_q, set ready_q[old ctx_sel_o];
    - go to RESUME.
  - RESUME (1 cycle): halt_req_o <= 0; switch_done_o = 1; go to RUN.
- Winner stability: the winner is frozen at DRAIN entry. Later wakes and ctx_en_i changes do not alter next_q. If ctx_en_i[next_q] drops during DRAIN, the switch still completes.
- Latency: from the yield cycle to switch_done_o = 3 + N cycles, where N is the number of DRAIN cycles (N >= 1). ctx_sel_o changes in the cycle before switch_done_o.
- ctx_sel_o changes only in SWITCH, and only while halt_req_o = 1 with halt_ack_i seen. The register file never sees a select change while the pipeline is live.
- halt_ack_i outside DRAIN is ignored. Yield and sleep outside RUN are ignored.

Optional Feature:
Macro: AXUM_CTX_PREEMPT_EN.
- Defined:
  - A 16-bit quantum counter clears to 0 on reset and in RESUME, and increments each RUN cycle.
  - When it reaches QuantumCycles-1 it raises an internal preempt signal. Preempt is treated as ctx_yield_i (requeue).
  - If cand == 0 at that point, the counter saturates and preempt stays pending until a candidate appears.
  - An explicit sleep in the same cycle takes priority (no requeue).
- Not defined: no counter is present, and switches occur only on yield or sleep.

Test Plan:
1. Reset, then pulse ctx_wake_i=4'b0100 and pulse yield; hold halt_ack_i low 3 cycles, then high → halt_req_o high for 3+2 cycles, ctx_sel_o=2, switch_done_o pulses at yield+6, ready_o=4'b0001.
2. From ctx 1 with ready_q=4'b1001, yield → winner 3, not 0 (round-robin from 2); next yield from 3 → winner 0 (wrap).
3. Only ctx 0 running, ready_q=0, assert yield → no halt_req_o, ctx_sel_o stays 0, busy_o stays 0.
4. Sleep from ctx 0 with ctx 1 ready; pulse ctx_wake_i[0] during DRAIN → after switch, ctx_sel_o=1 and ready_o[0]=1. The same test with yield instead of sleep also gives ready_o[0]=1.
5. ctx_en_i=4'b1101 with ready_q=4'b0110 from ctx 0 → winner 2. Assert rst_ni low during DRAIN → ctx_sel_o=0, halt_req_o=0 immediately.
6. With AXUM_CTX_PREEMPT_EN and QuantumCycles=16, ctx 1 ready, no yield → halt_req_o rises 16 cycles after the last RESUME, and ctx_sel_o switches. With no candidate ready, halt_req_o stays 0.

Source files
------------

// File: rtl/axum_ctx_sched.sv
// Context scheduler: drains the core via halt handshake, picks next ready context round-robin, updates the register-context select.
// Optional time-slice preemption is enabled by defining AXUM_CTX_PREEMPT_EN.
module axum_ctx_sched #(
    parameter int unsigned NrCtx         = 4,
    parameter int unsigned QuantumCycles = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NrCtx-1:0]         ctx_wake_i,
    input  logic [NrCtx-1:0]         ctx_en_i,
    input  logic                     ctx_yield_i,
    input  logic                     ctx_sleep_i,
    output logic                     halt_req_o,
    input  logic                     halt_ack_i,
    output logic [$clog2(NrCtx)-1:0] ctx_sel_o,
    output logic                     switch_done_o,
    output logic                     busy_o,
    output logic [NrCtx-1:0]         ready_o
);

    localparam int unsigned CtxW = $clog2(NrCtx);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_SWITCH = 2'd2,
        S_RESUME = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [NrCtx-1:0]  ready_q, ready_d;
    logic [CtxW-1:0]   next_q, next_d;
    logic              requeue_q, requeue_d;
    logic [CtxW-1:0]   sel_q, sel_d;
    logic              halt_q, halt_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic [NrCtx-1:0]  cand;
    logic [CtxW-1:0]   winner;
    logic [CtxW-1:0]   idx;
    logic              found;
    logic              has_cand;
    logic              preempt;
    logic              req;

`ifdef AXUM_CTX_PREEMPT_EN
    logic [15:0] quantum_q;

    // Counter saturates at the quantum limit so preemption stays pending until a candidate exists.
    assign preempt = (state_q == S_RUN) && (quantum_q == 16'(QuantumCycles - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            quantum_q <= '0;
        end else if (state_q == S_RESUME) begin
            quantum_q <= '0;
        end else if ((state_q == S_RUN) && !preempt) begin
            quantum_q <= quantum_q + 16'd1;
        end
    end
`else
    assign preempt = 1'b0;
`endif

    assign req = ctx_yield_i | ctx_sleep_i | preempt;

    // Round-robin search starting just above the running context.
    always_comb begin
        cand        = ready_q & ctx_en_i;
        cand[sel_q] = 1'b0;
        winner      = sel_q;
        idx         = '0;
        found       = 1'b0;
        for (int unsigned i = 1; i < NrCtx; i++) begin
            idx = CtxW'(sel_q + CtxW'(i));
            if (!found && cand[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
        has_cand = found;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_RUN;
            ready_q   <= '0;
            next_q    <= '0;
            requeue_q <= 1'b0;
            sel_q     <= '0;
            halt_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            next_q    <= next_d;
            requeue_q <= requeue_d;
            sel_q     <= sel_d;
            halt_q    <= halt_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:    if (req && has_cand) state_d = S_DRAIN;
            S_DRAIN:  if (halt_ack_i) state_d = S_SWITCH;
            S_SWITCH: state_d = S_RESUME;
            S_RESUME: state_d = S_RUN;
            default:  state_d = S_RUN;
        endcase
    end

    always_comb begin
        ready_d   = ready_q | ctx_wake_i;
        next_d    = next_q;
        requeue_d = requeue_q;
        sel_d     = sel_q;
        halt_d    = halt_q;
        done_d    = 1'b0;
        busy_d    = (state_d != S_RUN);
        case (state_q)
            S_RUN: begin
                // The running context cannot be woken.
                ready_d[sel_q] = ready_q[sel_q];
                if (req && has_cand) begin
                    next_d    = winner;
                    requeue_d = ~ctx_sleep_i & (ctx_yield_i | preempt);
                    halt_d    = 1'b1;
                end
            end
            S_SWITCH: begin
                sel_d           = next_q;
                ready_d[next_q] = 1'b0;
                if (requeue_q) ready_d[sel_q] = 1'b1;
            end
            S_RESUME: begin
                halt_d = 1'b0;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign halt_req_o    = halt_q;
    assign ctx_sel_o     = sel_q;
    assign switch_done_o = done_q;
    assign busy_o        = busy_q;
    assign ready_o       = ready_q;

endmodule
